// File: rtl/spi_master_shift_if.sv
// Control/pad bundle for spi_master_shift: host handshake, mode inputs and SPI pins.
interface spi_master_shift_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             cpol;
  logic             cphase;
  logic             lsb_first;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             spi_clk;
  logic             mosi;
  logic             miso;
  logic             cs_n;

  modport master (
    input  start, tx_data, cpol, cphase, lsb_first, miso,
    output busy, done, rx_data, spi_clk, mosi, cs_n
  );

  modport slave (
    output start, tx_data, cpol, cphase, lsb_first, miso,
    input  busy, done, rx_data, spi_clk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_shift.sv
// Full-duplex SPI master shift engine with run-time CPOL/CPHA, bit order and
// chip-select framing (setup, hold, gap) around each WIDTH-bit transfer.
module spi_master_shift #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input logic             clk,
  input logic             rst,
  spi_master_shift_if.master bus
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [WIDTH-1:0]  tx_shift;
  logic [WIDTH-1:0]  rx_shift;
  logic              cpol_r;
  logic              cpha_r;
  logic              lsb_r;
  logic              busy_r;
  logic              done_r;
  logic [WIDTH-1:0]  rx_data_r;
  logic              sclk_r;
  logic              mosi_r;
  logic              cs_n_r;

  logic tick;
  logic leading;
  logic last_edge;
  logic sample_now;
  logic advance_now;

  assign tick      = (div_cnt == DIV_LAST);
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EDGE_LAST);

  // The first bit is already on mosi at cs_n fall, so CPHA=1 skips the first
  // leading-edge advance and CPHA=0 skips the final trailing one.
  assign sample_now  = cpha_r ? ~leading : leading;
  assign advance_now = cpha_r ? (leading && (edge_cnt != '0))
                              : (~leading && !last_edge);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      lsb_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rx_data_r <= '0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      cs_n_r    <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          edge_cnt <= '0;
          sclk_r   <= bus.cpol;
          if (bus.start) begin
            tx_shift <= bus.tx_data;
            rx_shift <= '0;
            cpol_r   <= bus.cpol;
            cpha_r   <= bus.cphase;
            lsb_r    <= bus.lsb_first;
            busy_r   <= 1'b1;
            cs_n_r   <= 1'b0;
            mosi_r   <= bus.lsb_first ? bus.tx_data[0] : bus.tx_data[WIDTH-1];
            state    <= SETUP;
          end
        end

        SETUP: begin
          sclk_r <= cpol_r;
          if (tick) begin
            div_cnt <= '0;
            state   <= XFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        XFER: begin
          if (tick) begin
            div_cnt <= '0;
            sclk_r  <= ~sclk_r;
            if (sample_now) begin
              if (lsb_r) rx_shift <= {bus.miso, rx_shift[WIDTH-1:1]};
              else       rx_shift <= {rx_shift[WIDTH-2:0], bus.miso};
            end
            if (advance_now) begin
              if (lsb_r) begin
                tx_shift <= tx_shift >> 1;
                mosi_r   <= tx_shift[1];
              end else begin
                tx_shift <= tx_shift << 1;
                mosi_r   <= tx_shift[WIDTH-2];
              end
            end
            if (last_edge) begin
              edge_cnt <= '0;
              state    <= HOLD;
            end else begin
              edge_cnt <= edge_cnt + EDGE_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HOLD: begin
          if (tick) begin
            div_cnt   <= '0;
            cs_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
            rx_data_r <= rx_shift;
            done_r    <= 1'b1;
            state     <= GAP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        GAP: begin
          if (tick) begin
            div_cnt <= '0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rx_data = rx_data_r;
  assign bus.spi_clk = sclk_r;
  assign bus.mosi    = mosi_r;
  assign bus.cs_n    = cs_n_r;

endmodule

// File: tb/tb_spi_master_shift.sv
// Directed bench for spi_master_shift: a CLK_DIV=2 instance for mode/abort cases
// and a CLK_DIV=1 instance for back-to-back transfers, scoreboarded on done.
module tb_spi_master_shift;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  spi_master_shift_if #(.WIDTH(8)) ifa ();
  spi_master_shift_if #(.WIDTH(8)) ifb ();

  spi_master_shift #(.WIDTH(8), .CLK_DIV(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  spi_master_shift #(.WIDTH(8), .CLK_DIV(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Slave model for instance A: loopback or a pattern updated on falling SCLK.
  exp_t        sb_a[$];
  logic        loop_a = 1'b1;
  logic [7:0]  pat_a = '0;
  logic        pat_bit_a;
  logic        prev_sclk_a, prev_busy_a;
  logic [7:0]  cap_a;
  int unsigned rise_a, fall_a, edges_a, busy_cyc_a, done_hi_a;

  assign ifa.miso = loop_a ? ifa.mosi : pat_bit_a;

  always @(negedge clk) begin
    if (rst) begin
      prev_sclk_a <= 1'b0;
      prev_busy_a <= 1'b0;
      pat_bit_a   <= 1'b0;
      cap_a       <= '0;
      rise_a      <= 0;
      fall_a      <= 0;
      edges_a     <= 0;
      busy_cyc_a  <= 0;
      done_hi_a   <= 0;
    end else begin
      prev_sclk_a <= ifa.spi_clk;
      prev_busy_a <= ifa.busy;
      if (!ifa.cs_n && (ifa.spi_clk != prev_sclk_a)) begin
        edges_a <= edges_a + 1;
        if (ifa.spi_clk) begin
          cap_a  <= {cap_a[6:0], ifa.mosi};
          rise_a <= rise_a + 1;
        end else if (fall_a < 8) begin
          pat_bit_a <= pat_a[3'(7 - fall_a)];
          fall_a    <= fall_a + 1;
        end
      end
      if (ifa.busy) busy_cyc_a <= busy_cyc_a + 1;
      if (ifa.done) begin
        done_hi_a <= done_hi_a + 1;
        if (sb_a.size() == 0) begin
          chk("a_extra_done", {31'b0, ifa.done}, 32'd0);
        end else begin
          exp_t e;
          e = sb_a.pop_front();
          chk("a_rx_data", {24'b0, ifa.rx_data}, {24'b0, e.rx});
          chk("a_mosi_seq", {24'b0, cap_a}, {24'b0, e.seq});
          chk("a_sclk_rises", rise_a, 32'd8);
        end
        rise_a  <= 0;
        fall_a  <= 0;
        edges_a <= 0;
      end
      if (prev_busy_a && !ifa.busy) begin
        chk("a_busy_len", busy_cyc_a, 32'd38);
        chk("a_done_pulses", done_hi_a, 32'd1);
        busy_cyc_a <= 0;
        done_hi_a  <= 0;
      end
    end
  end

  // Instance B: loopback, scoreboard plus cs_n-high gap measurement.
  exp_t        sb_b[$];
  logic        prev_cs_b;
  int unsigned cs_hi_b, done_b;

  assign ifb.miso = ifb.mosi;

  always @(negedge clk) begin
    if (rst) begin
      prev_cs_b <= 1'b1;
      cs_hi_b   <= 0;
      done_b    <= 0;
    end else begin
      prev_cs_b <= ifb.cs_n;
      cs_hi_b   <= ifb.cs_n ? cs_hi_b + 1 : 0;
      if (!ifb.cs_n && prev_cs_b && done_b > 0)
        chk("b_cs_gap", cs_hi_b, 32'd2);
      if (ifb.done) begin
        done_b <= done_b + 1;
        if (sb_b.size() == 0) begin
          chk("b_extra_done", {31'b0, ifb.done}, 32'd0);
        end else begin
          exp_t e;
          e = sb_b.pop_front();
          chk("b_rx_data", {24'b0, ifb.rx_data}, {24'b0, e.rx});
        end
      end
    end
  end

  task automatic pulse_start_a();
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    for (int i = 0; i < 200 && ifa.busy; i++) @(negedge clk);
    chk(tag, {31'b0, ifa.busy}, 32'd0);
  endtask

  task automatic push_a(input logic [7:0] rx, input logic [7:0] tx, input logic lsb);
    exp_t e;
    e.rx  = rx;
    e.seq = lsb ? rev8(tx) : tx;
    sb_a.push_back(e);
  endtask

  initial begin
    ifa.start = 1'b0; ifa.tx_data = '0; ifa.cpol = 1'b0; ifa.cphase = 1'b0; ifa.lsb_first = 1'b0;
    ifb.start = 1'b0; ifb.tx_data = '0; ifb.cpol = 1'b0; ifb.cphase = 1'b0; ifb.lsb_first = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n",    {31'b0, ifa.cs_n},    32'd1);
    chk("rst_busy",    {31'b0, ifa.busy},    32'd0);
    chk("rst_done",    {31'b0, ifa.done},    32'd0);
    chk("rst_sclk",    {31'b0, ifa.spi_clk}, 32'd0);
    chk("rst_mosi",    {31'b0, ifa.mosi},    32'd0);
    chk("rst_rx_data", {24'b0, ifa.rx_data}, 32'd0);
    rst = 1'b0;

    // Mode 0, loopback
    ifa.tx_data = 8'hA5;
    push_a(8'hA5, 8'hA5, 1'b0);
    pulse_start_a();
    chk("m0_cs_low", {31'b0, ifa.cs_n}, 32'd0);
    wait_idle_a("m0_busy_end");

    // Mode 3, slave pattern 0xC3
    ifa.cpol = 1'b1; ifa.cphase = 1'b1; loop_a = 1'b0; pat_a = 8'hC3;
    repeat (2) @(negedge clk);
    chk("m3_idle_sclk", {31'b0, ifa.spi_clk}, 32'd1);
    ifa.tx_data = 8'h3C;
    push_a(8'hC3, 8'h3C, 1'b0);
    pulse_start_a();
    wait_idle_a("m3_busy_end");

    // LSB-first, mode 0, loopback
    ifa.cpol = 1'b0; ifa.cphase = 1'b0; loop_a = 1'b1; ifa.lsb_first = 1'b1;
    repeat (2) @(negedge clk);
    ifa.tx_data = 8'h01;
    push_a(8'h01, 8'h01, 1'b1);
    pulse_start_a();
    wait_idle_a("lsb_busy_end");

    // Start pulse and tx_data change mid-transfer are ignored
    ifa.lsb_first = 1'b0;
    ifa.tx_data = 8'h5A;
    push_a(8'h5A, 8'h5A, 1'b0);
    pulse_start_a();
    for (int i = 0; i < 100 && rise_a < 3; i++) @(negedge clk);
    chk("mid_cs_low", {31'b0, ifa.cs_n}, 32'd0);
    chk("mid_rx_held", {24'b0, ifa.rx_data}, 32'h01);
    ifa.tx_data = 8'hFF;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_idle_a("mid_busy_end");
    repeat (4) @(negedge clk);
    chk("mid_no_restart", {31'b0, ifa.busy}, 32'd0);

    // Asynchronous reset at XFER edge 5
    ifa.tx_data = 8'hC3;
    pulse_start_a();
    for (int i = 0; i < 100 && edges_a < 5; i++) @(negedge clk);
    chk("abort_edges", edges_a, 32'd5);
    #1 rst = 1'b1;
    #1;
    chk("abort_cs_n",    {31'b0, ifa.cs_n},    32'd1);
    chk("abort_sclk",    {31'b0, ifa.spi_clk}, 32'd0);
    chk("abort_busy",    {31'b0, ifa.busy},    32'd0);
    chk("abort_done",    {31'b0, ifa.done},    32'd0);
    chk("abort_rx_data", {24'b0, ifa.rx_data}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    ifa.tx_data = 8'h96;
    push_a(8'h96, 8'h96, 1'b0);
    pulse_start_a();
    wait_idle_a("post_abort_busy_end");

    // Back-to-back on the CLK_DIV=1 instance
    ifb.tx_data = 8'h69;
    begin
      exp_t e;
      e.rx = 8'h69; e.seq = 8'h69;
      sb_b.push_back(e);
      sb_b.push_back(e);
    end
    @(negedge clk);
    ifb.start = 1'b1;
    for (int i = 0; i < 200 && done_b < 2; i++) begin
      @(negedge clk);
      #1;
    end
    ifb.start = 1'b0;
    for (int i = 0; i < 50 && ifb.busy; i++) @(negedge clk);
    chk("b_busy_end", {31'b0, ifb.busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("b_done_count", done_b, 32'd2);
    chk("b_stays_idle", {31'b0, ifb.busy}, 32'd0);

    chk("sb_a_drained", sb_a.size(), 32'd0);
    chk("sb_b_drained", sb_b.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
